// File: rtl/uart_rx_majority.sv
// 8N1 UART receiver with a 3-sample majority vote around mid-bit.
// Start-bit glitches are rejected. Framing errors and breaks are reported as one-cycle pulses.
// A good frame produces a one-cycle oRX_VALID strobe, and oRX_DATA holds the byte until the next strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle; waiting for a falling edge on the synced input
// START  | start bit; a majority-high vote aborts as a glitch
// DATA   | eight data bits, LSB first, shifted in at mid-bit
// STOP   | stop bit; result is registered at mid-bit, then back to IDLE

module uart_rx_majority #(
    parameter logic [19:0] P_BIT_CLKS = 20'd108
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iRESET_SYNC,
    input  logic       iUART_RXD,
    output logic       oRX_VALID,
    output logic [7:0] oRX_DATA,
    output logic       oRX_FRAME_ERR,
    output logic       oRX_BREAK,
    output logic       oRX_BUSY
);

    localparam logic [19:0] H       = P_BIT_CLKS >> 1;
    localparam logic [19:0] C_SMP_A = H - 20'd1;
    localparam logic [19:0] C_SMP_B = H;
    localparam logic [19:0] C_MID   = H + 20'd1;
    localparam logic [19:0] C_EOB   = P_BIT_CLKS - 20'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic [19:0] cnt_q,     cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  data_q,    data_d;
    logic        sync1_q,   sync1_d;
    logic        sync2_q,   sync2_d;
    logic        prev_q,    prev_d;
    logic        samp_a_q,  samp_a_d;
    logic        samp_b_q,  samp_b_d;
    logic        valid_q,   valid_d;
    logic        ferr_q,    ferr_d;
    logic        brk_q,     brk_d;

    logic fall_edge;
    logic at_mid;
    logic at_eob;
    logic maj;

    // The third vote comes straight from the synchronizer, so the decision lands at H+1.
    assign fall_edge = ~sync2_q & prev_q;
    assign at_mid    = (cnt_q == C_MID);
    assign at_eob    = (cnt_q == C_EOB);
    assign maj       = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q) | (samp_b_q & sync2_q);

    // Next-state, datapath and strobe generation; a synchronous reset overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        samp_a_d  = samp_a_q;
        samp_b_d  = samp_b_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        brk_d     = 1'b0;
        sync1_d   = iUART_RXD;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;

        if (state_q != S_IDLE) begin
            cnt_d = at_eob ? 20'd0 : cnt_q + 20'd1;
            if (cnt_q == C_SMP_A) samp_a_d = sync2_q;
            if (cnt_q == C_SMP_B) samp_b_d = sync2_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = 20'd0;
                if (fall_edge) state_d = S_START;
            end
            S_START: begin
                if (at_mid && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = 20'd0;
                end else if (at_eob) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (at_mid) shift_d = {maj, shift_q[7:1]};
                if (at_eob) begin
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit of slack for the next start edge.
                if (at_mid) begin
                    state_d   = S_IDLE;
                    cnt_d     = 20'd0;
                    bit_idx_d = 3'd0;
                    if (maj) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = (shift_q == 8'h00);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (iRESET_SYNC) begin
            state_d   = S_IDLE;
            cnt_d     = 20'd0;
            bit_idx_d = 3'd0;
            shift_d   = 8'h00;
            data_d    = 8'h00;
            samp_a_d  = 1'b1;
            samp_b_d  = 1'b1;
            valid_d   = 1'b0;
            ferr_d    = 1'b0;
            brk_d     = 1'b0;
            sync1_d   = 1'b1;
            sync2_d   = 1'b1;
            prev_d    = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= 20'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            samp_a_q  <= 1'b1;
            samp_b_q  <= 1'b1;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            samp_a_q  <= samp_a_d;
            samp_b_q  <= samp_b_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
        end
    end

    assign oRX_VALID     = valid_q;
    assign oRX_DATA      = data_q;
    assign oRX_FRAME_ERR = ferr_q;
    assign oRX_BREAK     = brk_q;
    assign oRX_BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_majority.sv
// Directed bench for uart_rx_majority with 16 clocks per bit (H = 8).
// Frame cases run from a vector table, and the multi-cycle corner cases are written out by hand.

module tb_uart_rx_majority;

    localparam int BIT = 16;
    localparam int EXP_LAT = 156;   // 9*16 + 8 + 4

    logic       iCLOCK = 1'b0;
    logic       inRESET = 1'b0;
    logic       iRESET_SYNC = 1'b0;
    logic       iUART_RXD = 1'b1;
    logic       oRX_VALID;
    logic [7:0] oRX_DATA;
    logic       oRX_FRAME_ERR;
    logic       oRX_BREAK;
    logic       oRX_BUSY;

    uart_rx_majority #(.P_BIT_CLKS(20'd16)) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iRESET_SYNC   (iRESET_SYNC),
        .iUART_RXD     (iUART_RXD),
        .oRX_VALID     (oRX_VALID),
        .oRX_DATA      (oRX_DATA),
        .oRX_FRAME_ERR (oRX_FRAME_ERR),
        .oRX_BREAK     (oRX_BREAK),
        .oRX_BUSY      (oRX_BUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    int cyc = 0;
    always @(posedge iCLOCK) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge, away from the active edge.
    int n_valid = 0, n_ferr = 0, n_brk = 0, n_brk_alone = 0;
    int last_valid_cyc = 0, last_ferr_cyc = 0;
    logic [7:0] rx_q[$];
    always @(negedge iCLOCK) begin
        if (oRX_VALID) begin
            n_valid++;
            last_valid_cyc = cyc;
            rx_q.push_back(oRX_DATA);
        end
        if (oRX_FRAME_ERR) begin
            n_ferr++;
            last_ferr_cyc = cyc;
        end
        if (oRX_BREAK) begin
            n_brk++;
            if (!oRX_FRAME_ERR) n_brk_alone++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int   start_edge;
    logic busy_after_rst;

    // Drives one frame; each loop iteration starts just after a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int clks,
                              input logic spike, input int rst_bit);
        logic [9:0] fr;
        fr = {stop_b, d, 1'b0};
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < clks; k++) begin
                if (n == 0 && k == 0) start_edge = cyc + 1;
                if (n == rst_bit && k == 5) busy_after_rst = oRX_BUSY;
                iUART_RXD   = (spike && fr[n] && n >= 1 && n <= 8 && k == 9) ? 1'b0 : fr[n];
                iRESET_SYNC = (n == rst_bit && k == 4);
                @(negedge iCLOCK);
            end
        end
        iRESET_SYNC = 1'b0;
        iUART_RXD   = 1'b1;
    endtask

    task automatic idle(input int n);
        iUART_RXD = 1'b1;
        repeat (n) @(negedge iCLOCK);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         bit_clks;
        logic       spike;
        int         exp_valid;
        int         exp_ferr;
        int         exp_brk;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int b_valid, b_ferr, b_brk, b_alone, b_q;

    task automatic snap();
        b_valid = n_valid;
        b_ferr  = n_ferr;
        b_brk   = n_brk;
        b_alone = n_brk_alone;
        b_q     = rx_q.size();
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 16, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h55, 1'b0, 16, 1'b0, 0, 1, 0, 8'hA5};
        vecs[2] = '{8'h00, 1'b0, 16, 1'b0, 0, 1, 1, 8'hA5};
        vecs[3] = '{8'h3C, 1'b1, 16, 1'b1, 1, 0, 0, 8'h3C};
        vecs[4] = '{8'hFF, 1'b1, 17, 1'b0, 1, 0, 0, 8'hFF};
        vecs[5] = '{8'h00, 1'b1, 16, 1'b1, 1, 0, 0, 8'h00};

        // Reset values, during and after reset.
        repeat (3) @(negedge iCLOCK);
        check("rst_valid", int'(oRX_VALID), 0);
        check("rst_data", int'(oRX_DATA), 8'h00);
        check("rst_busy", int'(oRX_BUSY), 0);
        inRESET = 1'b1;
        repeat (3) @(negedge iCLOCK);
        check("post_rst_valid", int'(oRX_VALID), 0);
        check("post_rst_ferr", int'(oRX_FRAME_ERR), 0);
        check("post_rst_brk", int'(oRX_BREAK), 0);
        check("post_rst_data", int'(oRX_DATA), 8'h00);
        check("post_rst_busy", int'(oRX_BUSY), 0);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].bit_clks, vecs[i].spike, -1);
            idle(40);
            check($sformatf("v%0d_valid", i), n_valid - b_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_ferr", i), n_ferr - b_ferr, vecs[i].exp_ferr);
            check($sformatf("v%0d_brk", i), n_brk - b_brk, vecs[i].exp_brk);
            check($sformatf("v%0d_data", i), int'(oRX_DATA), int'(vecs[i].exp_data));
            check($sformatf("v%0d_busy", i), int'(oRX_BUSY), 0);
            if (vecs[i].bit_clks == BIT && vecs[i].exp_valid == 1)
                check($sformatf("v%0d_lat", i), last_valid_cyc - start_edge, EXP_LAT);
            if (vecs[i].bit_clks == BIT && vecs[i].exp_ferr == 1)
                check($sformatf("v%0d_ferr_lat", i), last_ferr_cyc - start_edge, EXP_LAT);
        end

        // Back-to-back frames with a stretched 17-clock bit and no idle gap.
        snap();
        send_frame(8'h00, 1'b1, 17, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 17, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 17, 1'b0, -1);
        idle(40);
        check("b2b_count", n_valid - b_valid, 3);
        check("b2b_ferr", n_ferr - b_ferr, 0);
        if (rx_q.size() >= b_q + 3) begin
            check("b2b_byte0", int'(rx_q[b_q]), 8'h00);
            check("b2b_byte1", int'(rx_q[b_q + 1]), 8'hFF);
            check("b2b_byte2", int'(rx_q[b_q + 2]), 8'h3C);
        end else begin
            check("b2b_queue", rx_q.size() - b_q, 3);
        end

        // Start-bit glitch: four low cycles.
        snap();
        iUART_RXD = 1'b0;
        repeat (4) @(negedge iCLOCK);
        check("glitch_busy_high", int'(oRX_BUSY), 1);
        idle(40);
        check("glitch_valid", n_valid - b_valid, 0);
        check("glitch_ferr", n_ferr - b_ferr, 0);
        check("glitch_busy_low", int'(oRX_BUSY), 0);

        // Break: line low for 20 bit times, then released.
        snap();
        start_edge = cyc + 1;
        iUART_RXD = 1'b0;
        repeat (20 * BIT) @(negedge iCLOCK);
        check("brk_ferr", n_ferr - b_ferr, 1);
        check("brk_brk", n_brk - b_brk, 1);
        check("brk_coincide", n_brk_alone - b_alone, 0);
        check("brk_lat", last_ferr_cyc - start_edge, EXP_LAT);
        check("brk_valid", n_valid - b_valid, 0);
        check("brk_busy_low", int'(oRX_BUSY), 0);
        check("brk_data_held", int'(oRX_DATA), 8'h3C);
        idle(40);
        check("brk_quiet_ferr", n_ferr - b_ferr, 1);
        send_frame(8'h81, 1'b1, BIT, 1'b0, -1);
        idle(40);
        check("brk_after_valid", n_valid - b_valid, 1);
        check("brk_after_data", int'(oRX_DATA), 8'h81);

        // Synchronous reset during data bit 3 abandons the frame.
        snap();
        busy_after_rst = 1'b1;
        send_frame(8'hF8, 1'b1, BIT, 1'b0, 4);
        idle(40);
        check("srst_busy_now", int'(busy_after_rst), 0);
        check("srst_valid", n_valid - b_valid, 0);
        check("srst_ferr", n_ferr - b_ferr, 0);
        check("srst_data", int'(oRX_DATA), 8'h00);
        send_frame(8'h81, 1'b1, BIT, 1'b0, -1);
        idle(40);
        check("srst_next_valid", n_valid - b_valid, 1);
        check("srst_next_data", int'(oRX_DATA), 8'h81);
        check("srst_next_lat", last_valid_cyc - start_edge, EXP_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_majority.md
Name: uart_rx_majority

Overview:
- Serial-to-parallel UART receiver for the SCI device: 8N1 frames, LSB first, fixed clock-per-bit divisor.
- Each bit is decided by a 3-sample majority vote around mid-bit.
- Start-bit glitches are rejected. Framing-error and break events are flagged.
- Output is a single-cycle valid strobe plus a byte, suitable for direct connection to the RX write port of the SCI sync FIFO.

Parameters:
- P_BIT_CLKS, 20'd108, iCLOCK cycles per UART bit (115200 baud); legal range >= 4. H = P_BIT_CLKS/2 (integer division).

Ports:
- iCLOCK  input  1  system clock; all logic is on the rising edge.
- inRESET  input  1  asynchronous active-low reset.
- iRESET_SYNC  input  1  synchronous reset; same effect as inRESET, applied at the clock edge.
- iUART_RXD  input  1  asynchronous serial line; idle is high.
- oRX_VALID  output  1  one-cycle pulse: good frame received.
- oRX_DATA  output  8  received byte; held until the next oRX_VALID.
- oRX_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- oRX_BREAK  output  1  one-cycle pulse: framing error with data == 8'h00; coincides with oRX_FRAME_ERR.
- oRX_BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (inRESET low, or iRESET_SYNC high at an edge):
  - state = IDLE; bit counter and clock counter = 0; shift register = 8'h00.
  - Both synchronizer flops and the previous-sample flop = 1.
  - oRX_VALID, oRX_FRAME_ERR, oRX_BREAK, oRX_BUSY = 0; oRX_DATA = 8'h00.
  - A reset mid-frame abandons the frame. No strobe is issued.
- Input path:
  - iUART_RXD passes through a 2-flop synchronizer (s2 is its output), then a third flop (prev).
  - A falling edge is s2 == 0 && prev == 1.
- Clock counter: 20 bits. Counts 0..P_BIT_CLKS-1 in every non-IDLE state and wraps to 0 at P_BIT_CLKS-1, which marks end of bit.
- Sampling: s2 is captured at counter H-1, H and H+1. The majority of those three samples is the bit value, decided at counter H+1.
- States:
  - IDLE: on a falling edge -> START with counter = 0.
  - START: at H+1, majority == 1 -> false start, go to IDLE (no strobe). Otherwise, at end of bit -> DATA with bit index = 0.
  - DATA: at H+1, shift the majority into bit 7 and shift right (LSB first). At end of bit: index 7 -> STOP; otherwise index+1.
  - STOP: at H+1, go to IDLE and register the result:
    - majority 1 -> oRX_DATA = shift register; oRX_VALID = 1 for exactly one cycle.
    - majority 0 -> oRX_FRAME_ERR = 1 for one cycle; oRX_BREAK = 1 as well if the shift register == 0. oRX_DATA is not updated.
- Stop-bit handling and idle re-entry:
  - Returning to IDLE at mid stop bit allows back-to-back frames at up to +/- ~4% baud mismatch.
  - IDLE requires a falling edge, so a line stuck low after a break or framing error never re-triggers. The line must first return high.
- Latency: oRX_VALID is high in exactly one cycle. That cycle begins 9*P_BIT_CLKS + H + 4 edges after the edge that first samples iUART_RXD low (edge 0). For the default, that is 1030.
- Flow control: there is no backpressure. The consumer must accept the byte in the strobe cycle.

Test Plan:
(All cases use P_BIT_CLKS = 16, so H = 8.)
- Reset values: reset asserted, then released with the line idle high -> all outputs 0, oRX_DATA = 8'h00, oRX_BUSY = 0.
- Single frame 8'hA5: send start, A5 LSB first, stop -> oRX_VALID pulses once at edge 156 after the start is first sampled; oRX_DATA = 8'hA5; no error pulses.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap, and the bit period stretched to 17 clocks -> three oRX_VALID pulses with the correct bytes.
- Glitch rejection: hold the line low for 4 cycles, then high -> no strobe, oRX_BUSY returns to 0. Separately, one-cycle low spikes at counter H inside a data bit -> the majority vote keeps the correct byte.
- Framing and break:
  - Frame 8'h55 with stop bit low -> oRX_FRAME_ERR = 1 for one cycle, oRX_BREAK = 0, oRX_DATA unchanged.
  - Line held low for 20 bit times -> oRX_FRAME_ERR and oRX_BREAK pulse once together, with no further events until the line returns high and a new start bit arrives.
- Reset mid-frame: pulse iRESET_SYNC during data bit 3 -> no strobe for that frame, state returns to IDLE. A subsequent clean 8'h81 frame is received correctly.
